// File: rtl/series_acc.sv
// series_acc: sums an arithmetic series, or the squares of its terms, through a
// three-stage pipeline (fetch -> operate -> accumulate).
//
// Parameters
//   DATA_W : term width in bits
//   CNT_W  : term-count width in bits
//   ACC_W  : accumulator width; must be >= 2*DATA_W
//
// Ports
//   clk      : single clock, all state changes on its rising edge
//   reset    : asynchronous active-high reset
//   start    : request a new series, sampled only in IDLE
//   first    : first term value
//   step     : increment between consecutive terms
//   count    : number of terms to sum (0 is legal)
//   mode     : 0 = sum of terms, 1 = sum of squared terms
//   busy     : high in every state except IDLE
//   done     : one-cycle completion pulse
//   sum_out  : accumulator value, wraps modulo 2^ACC_W
//   overflow : sticky carry-out-of-accumulator flag for the current series
module series_acc #(
   parameter int unsigned DATA_W = 10,
   parameter int unsigned CNT_W  = 10,
   parameter int unsigned ACC_W  = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] first,
   input  logic [DATA_W-1:0] step,
   input  logic [CNT_W-1:0]  count,
   input  logic              mode,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  sum_out,
   output logic              overflow
);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   term_q;
   logic [DATA_W-1:0]   step_q;
   logic [CNT_W-1:0]    remain_q;
   logic                mode_q;
   logic [1:0]          drain_q;

   // Pipeline registers
   logic                s1_valid_q;
   logic [DATA_W-1:0]   s1_data_q;
   logic                s2_valid_q;
   logic [ACC_W-1:0]    s2_data_q;

   logic [2*DATA_W-1:0] term_sq;
   logic [ACC_W-1:0]    s2_next;
   logic [ACC_W:0]      sum_ext;

   always_comb begin
      term_sq = s1_data_q * s1_data_q;
      s2_next = mode_q ? ACC_W'(term_sq) : ACC_W'(s1_data_q);
      // Extra MSB captures the carry out of the accumulator.
      sum_ext = {1'b0, sum_out} + {1'b0, s2_data_q};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         term_q     <= '0;
         step_q     <= '0;
         remain_q   <= '0;
         mode_q     <= 1'b0;
         drain_q    <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         sum_out    <= '0;
         overflow   <= 1'b0;
      end else begin
         // Stages 2 and 3 advance every cycle; invalid slots carry zero.
         s2_valid_q <= s1_valid_q;
         s2_data_q  <= s1_valid_q ? s2_next : '0;
         if (s2_valid_q) begin
            sum_out <= sum_ext[ACC_W-1:0];
            if (sum_ext[ACC_W]) begin
               overflow <= 1'b1;
            end
         end

         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         done       <= 1'b0;

         unique case (state_q)
            StIdle: begin
               if (start) begin
                  term_q   <= first;
                  step_q   <= step;
                  remain_q <= count;
                  mode_q   <= mode;
                  sum_out  <= '0;
                  overflow <= 1'b0;
                  busy     <= 1'b1;
                  state_q  <= StRun;
               end
            end

            StRun: begin
               if (remain_q != '0) begin
                  s1_valid_q <= 1'b1;
                  s1_data_q  <= term_q;
                  term_q     <= term_q + step_q;
                  remain_q   <= remain_q - 1'b1;
                  if (remain_q == CNT_W'(1)) begin
                     // Last term is in stage 1: two more edges empty the pipeline.
                     drain_q <= 2'd2;
                     state_q <= StDrain;
                  end
               end else begin
                  // count == 0: wait one drain cycle so latency stays count+3.
                  drain_q <= 2'd1;
                  state_q <= StDrain;
               end
            end

            StDrain: begin
               if (drain_q == 2'd0) begin
                  done    <= 1'b1;
                  state_q <= StDone;
               end else begin
                  drain_q <= drain_q - 1'b1;
               end
            end

            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end

            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_series_acc.sv
module tb_series_acc;

   localparam int unsigned DATA_W = 10;
   localparam int unsigned CNT_W  = 10;
   localparam int unsigned ACC_W  = 24;

   logic              clk;
   logic              reset;
   logic              start;
   logic [DATA_W-1:0] first;
   logic [DATA_W-1:0] step;
   logic [CNT_W-1:0]  count;
   logic              mode;
   logic              busy;
   logic              done;
   logic [ACC_W-1:0]  sum_out;
   logic              overflow;

   int n_total;
   int n_pass;

   series_acc #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W),
      .ACC_W  (ACC_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .first    (first),
      .step     (step),
      .count    (count),
      .mode     (mode),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] first;
      logic [DATA_W-1:0] step;
      logic [CNT_W-1:0]  count;
      logic              mode;
      logic [ACC_W-1:0]  exp_sum;
      logic              exp_ovf;
      int                restart_at;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Applies one series from mid-cycle; returns mid-cycle (#1 after an edge).
   task automatic run(input vec_t v);
      int  n;
      bit  got;
      first = v.first;
      step  = v.step;
      count = v.count;
      mode  = v.mode;
      start = 1'b1;
      @(posedge clk);  // E0
      #1;
      start = 1'b0;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      // Inputs are only sampled on the accept edge.
      first = DATA_W'($urandom);
      step  = DATA_W'($urandom);
      count = CNT_W'($urandom);
      mode  = ~v.mode;
      n   = 0;
      got = 1'b0;
      while (!got && n < int'(v.count) + 20) begin
         start = (v.restart_at != 0 && n + 1 == v.restart_at);
         @(posedge clk);
         n++;
         #1;
         start = 1'b0;
         if (done) got = 1'b1;
      end
      check("done_latency", got ? n : -1, int'(v.count) + 3);
      check("sum_out", 32'(sum_out), 32'(v.exp_sum));
      check("overflow", {31'd0, overflow}, {31'd0, v.exp_ovf});
      // start in the DONE cycle must be ignored.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("done_one_cycle_idle", {30'd0, busy, done}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("sum_hold_idle", 32'(sum_out), 32'(v.exp_sum));
      check("ovf_hold_idle", {31'd0, overflow}, {31'd0, v.exp_ovf});
   endtask

   vec_t vecs[9];
   int   done_seen;

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset   = 1'b0;
      start   = 1'b0;
      first   = '0;
      step    = '0;
      count   = '0;
      mode    = 1'b0;

      vecs[0] = '{first: 10'd1,    step: 10'd1, count: 10'd512, mode: 1'b0,
                  exp_sum: 24'd131328,  exp_ovf: 1'b0, restart_at: 0};
      vecs[1] = '{first: 10'd1,    step: 10'd1, count: 10'd10,  mode: 1'b1,
                  exp_sum: 24'd385,     exp_ovf: 1'b0, restart_at: 0};
      vecs[2] = '{first: 10'd5,    step: 10'd7, count: 10'd0,   mode: 1'b1,
                  exp_sum: 24'd0,       exp_ovf: 1'b0, restart_at: 0};
      vecs[3] = '{first: 10'd1023, step: 10'd0, count: 10'd20,  mode: 1'b1,
                  exp_sum: 24'd4153364, exp_ovf: 1'b1, restart_at: 0};
      vecs[4] = '{first: 10'd3,    step: 10'd2, count: 10'd4,   mode: 1'b0,
                  exp_sum: 24'd24,      exp_ovf: 1'b0, restart_at: 0};
      vecs[5] = '{first: 10'd3,    step: 10'd2, count: 10'd4,   mode: 1'b1,
                  exp_sum: 24'd164,     exp_ovf: 1'b0, restart_at: 0};
      // Terms 1020, 1023, 2 (term wraps at 2^10).
      vecs[6] = '{first: 10'd1020, step: 10'd3, count: 10'd3,   mode: 1'b0,
                  exp_sum: 24'd2045,    exp_ovf: 1'b0, restart_at: 0};
      vecs[7] = '{first: 10'd7,    step: 10'd9, count: 10'd1,   mode: 1'b1,
                  exp_sum: 24'd49,      exp_ovf: 1'b0, restart_at: 0};
      // start re-pulsed at E5 of a long run is ignored.
      vecs[8] = '{first: 10'd1,    step: 10'd1, count: 10'd512, mode: 1'b0,
                  exp_sum: 24'd131328,  exp_ovf: 1'b0, restart_at: 5};

      #1 reset = 1'b1;
      #1;
      check("reset_outputs", {7'd0, busy, done, overflow, sum_out}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // First accept on the first rising edge after release.
      for (int i = 0; i < 9; i++) begin
         run(vecs[i]);
      end

      // Reset mid-series, between edges, at cycle 100 of a run.
      first = 10'd1;
      step  = 10'd1;
      count = 10'd512;
      mode  = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      check("sum_nonzero_before_abort", {31'd0, sum_out != '0}, 32'd1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_clears", {7'd0, busy, done, overflow, sum_out}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      repeat (600) begin
         @(posedge clk);
         #1;
         if (done || busy) done_seen++;
      end
      check("no_done_after_abort", done_seen, 0);
      run(vecs[1]);
      run(vecs[3]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
